// File: rtl/calc_ctrl_fsm.sv
// Control sequencer for the small-calculator datapath: load, settle, execute, present one result.
module calc_ctrl_fsm #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       reuse,
  input  logic [1:0] op_sel,
  input  logic       abort,
  output logic [1:0] s1,
  output logic [1:0] wa,
  output logic       we,
  output logic [1:0] raa,
  output logic       rea,
  output logic [1:0] rab,
  output logic       reb,
  output logic [1:0] c,
  output logic       s2,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD1    = 3'd1,
    ST_LD2    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_OUT    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Datapath control word, MSB first in the order the datapath documents it.
  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
  } ctrl_t;

  localparam ctrl_t IDLE_WORD = ctrl_t'(14'b01_00_0_00_0_00_0_00_0);
  localparam ctrl_t LD1_WORD  = ctrl_t'(14'b11_01_1_00_0_00_0_00_0);
  localparam ctrl_t LD2_WORD  = ctrl_t'(14'b10_10_1_00_0_00_0_00_0);
  localparam ctrl_t OUT_WORD  = ctrl_t'(14'b01_00_0_11_1_11_1_01_1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_r, op_d;
  ctrl_t             word_q, word_d;
  logic              busy_d, done_d;

  // Moore decode of a state into its control word; EXEC carries the latched op.
  function automatic ctrl_t decode(input state_t st, input logic [OP_W-1:0] op);
    ctrl_t w;
    w = IDLE_WORD;
    case (st)
      ST_LD1:          w = LD1_WORD;
      ST_LD2:          w = LD2_WORD;
      ST_EXEC:         w = ctrl_t'({2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, op, 1'b0});
      ST_OUT, ST_DONE: w = OUT_WORD;
      default:         w = IDLE_WORD;
    endcase
    return w;
  endfunction

  // Next-state, settle counter, op latch, and next output word (outputs are registered).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_r;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            op_d    = op_sel;
            state_d = reuse ? ST_EXEC : ST_LD1;
          end
        end
        ST_LD1: state_d = ST_LD2;
        ST_LD2: begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_EXEC;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_EXEC: state_d = ST_OUT;
        ST_OUT:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    word_d = decode(state_d, op_d);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset parks everything on the Idle word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_r    <= '0;
      word_q  <= IDLE_WORD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_r    <= op_d;
      word_q  <= word_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign s1  = word_q.s1;
  assign wa  = word_q.wa;
  assign we  = word_q.we;
  assign raa = word_q.raa;
  assign rea = word_q.rea;
  assign rab = word_q.rab;
  assign reb = word_q.reb;
  assign c   = word_q.c;
  assign s2  = word_q.s2;

endmodule

// File: doc/calc_ctrl_fsm.md
Name: calc_ctrl_fsm

Overview:
- Control unit for the small-calculator datapath (DP); it sits directly upstream of DP and drives all of DP's control inputs.
- On a start request it sequences one operation: load In1 into R1, load In2 into R2, settle, execute the ALU op into R3, then read R3 back to DP.out.
- It supports a repeat mode that skips the loads and reuses R1/R2.
- It flags completion so a top level or bench can sample DP.out.

Parameters:
- SETTLE_CYCLES, 1, number of Idle-word cycles between the R2 load and EXEC; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  start request; sampled only in IDLE.
- reuse  input  1  sampled with go; 1 skips both loads and the settle phase.
- op_sel  input  2  ALU op: 11 add, 10 sub, 01 and, 00 xor; latched at accepted go.
- abort  input  1  synchronous abort to IDLE.
- s1  output  2  DP mux1 select.
- wa  output  2  RF write address.
- we  output  1  RF write enable.
- raa  output  2  RF read address A.
- rea  output  1  RF read enable A.
- rab  output  2  RF read address B.
- reb  output  1  RF read enable B.
- c  output  2  ALU op to DP.
- s2  output  1  DP mux2 select (1 drives DP.out).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; DP.out holds a valid result this cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces state=IDLE, op_r=00, settle counter=0, done=0, busy=0. Outputs take the Idle word.
  - Reset mid-operation abandons the sequence; no further writes occur.
- Control word ordering: {s1,wa,we,raa,rea,rab,reb,c,s2}, 14 bits. All control outputs are a Moore decode of the state register, plus op_r in EXEC.
- State words:
  - IDLE: 01_00_0_00_0_00_0_00_0.
  - LD1: 11_01_1_00_0_00_0_00_0 (R1<-In1).
  - LD2: 10_10_1_00_0_00_0_00_0 (R2<-In2).
  - SETTLE: Idle word.
  - EXEC: 00_11_1_01_1_10_1_op_r_0 (R3<-R1 op R2).
  - OUT: 01_00_0_11_1_11_1_01_1 (R3&R3 driven to out).
  - DONE: same word as OUT; done=1.
- Transitions, one state per cycle unless noted:
  - IDLE -> LD1 on go&!reuse.
  - IDLE -> EXEC on go&reuse.
  - IDLE holds while go=0.
  - op_r <= op_sel when go is accepted in IDLE.
  - LD1 -> LD2 -> SETTLE.
  - SETTLE lasts exactly SETTLE_CYCLES cycles: counter loads SETTLE_CYCLES-1 on entry, decrements, exits at 0. It then goes to EXEC.
  - EXEC -> OUT -> DONE -> IDLE.
- Latency: go high in cycle 0 with reuse=0 gives done=1 in cycle 5+SETTLE_CYCLES. With reuse=1, done=1 in cycle 3.
- go in any non-IDLE state is ignored. op_sel changes after acceptance do not affect c. go held high continuously restarts one cycle after DONE (IDLE sees it).
- abort high in any state returns to IDLE at the next edge; done stays 0. abort has priority over go in IDLE, so go is not accepted.
- If abort is asserted in EXEC, the RF write of that cycle still completes, because the word is already driven. No later states run.
- we=1 only in LD1, LD2 and EXEC. s2=1 only in OUT and DONE.
- Encoding of unused states: go to IDLE on the next edge.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, go=0 for 5 cycles -> outputs constant 01_00_0_00_0_00_0_00_0, busy=0, done=0.
- Add with DP attached: in1=3, in2=2, op_sel=11, go pulse, SETTLE_CYCLES=1 -> word sequence LD1, LD2, SETTLE, EXEC (c=11), OUT; done at cycle 6; DP.out=101.
- All ops across all 64 in1/in2 pairs:
  - Expected out: add (in1+in2)[2:0], sub (in1-in2)[2:0], and in1&in2, xor in1^in2.
  - Example: 2-5 -> 101.
- Reuse mode: after loading in1=6, in2=3, change DP inputs to 0, pulse go with reuse=1 and op_sel=00 -> no we in LD states; done at cycle 3; out=101.
- Abort and ignored go:
  - abort during LD2 -> IDLE next cycle; done never pulses; R3 unchanged.
  - go pulsed during EXEC -> ignored; exactly one done.
- SETTLE_CYCLES=4 with mid-sequence rst_n low during SETTLE -> immediate Idle word, busy=0; a later clean run gives done at cycle 9.
